ahb_bridge_arbiter: RTL and testbench
=====================================

Name: ahb_bridge_arbiter

Overview:
- Round-robin arbiter/mux that shares the single AHB slave port of the AHB-to-APB bridge between NUM_MASTERS AHB masters.
- Grants one master at a time and forwards its address/control to the bridge.
- Tracks the data-phase owner separately so Hwdata follows AHB pipelining.
- Broadcasts bridge Hreadyout back to all masters. Hrdata and Hresp are wired outside this block.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..8)
MAX_TENURE, 16, completed NONSEQ transfers allowed per grant when ARB_TIMEOUT_EN is defined (>=1)
MW, $clog2(NUM_MASTERS), width of master index

Ports:
Hclk  in  1  bridge clock
Hresetn  in  1  asynchronous active-low reset
m_Hbusreq  in  NUM_MASTERS  bus request, one bit per master
m_Haddr  in  NUM_MASTERS*32  flattened per-master address, master i at [32i+:32]
m_Htrans  in  NUM_MASTERS*2  flattened per-master Htrans
m_Hwrite  in  NUM_MASTERS  per-master Hwrite
m_Hwdata  in  NUM_MASTERS*32  flattened per-master write data
Hreadyout  in  1  ready from bridge
Hgrant  out  NUM_MASTERS  one-hot registered grant
Hmaster  out  MW  address-phase owner index
m_Hready  out  1  Hreadyout broadcast to all masters
Haddr  out  32  to bridge
Htrans  out  2  to bridge
Hwrite  out  1  to bridge
Hwdata  out  32  to bridge
Hreadyin  out  1  to bridge, equals Hreadyout

Behaviour:
Reset (async, Hresetn=0):
- Hgrant=0, Hmaster=0, dmaster=0, last=NUM_MASTERS-1, state=ARB_IDLE, tenure=0.
- Combinational outputs in reset: Htrans=2'b00, Haddr=0, Hwrite=0, Hwdata=0.
- Reset asserted mid-transfer aborts immediately. Htrans is forced IDLE in the same cycle.

Grant rule:
- All state, grant and dmaster updates happen only on a Hclk edge with Hreadyout=1.
- While Hreadyout=0, everything holds.

Round-robin arbitration:
- The winner is the first requester searching from last+1, wrapping modulo NUM_MASTERS.
- On each grant, last <= winner.

FSM states:
- ARB_IDLE:
  - Htrans out = 00; Hgrant = 0.
  - If any m_Hbusreq: grant winner (Hgrant one-hot, Hmaster=winner) and go to ARB_OWNED.
- ARB_OWNED:
  - Haddr/Htrans/Hwrite = m_*[Hmaster].
  - Stay while owner's m_Hbusreq=1.
  - When owner's m_Hbusreq=0 and its Htrans=00: go to ARB_HANDOVER and clear Hgrant.
- ARB_HANDOVER (exactly one ready cycle):
  - Htrans out forced 00, Haddr held at last owner.
  - Lets the last data phase complete.
  - Then: if any request, grant winner (may be the same master if it is the sole requester) and go to ARB_OWNED; else go to ARB_IDLE.

Data phase:
- dmaster <= Hmaster on every ready edge while Htrans out is NONSEQ or SEQ.
- Hwdata = m_Hwdata[dmaster] at all times.
- This gives 1-cycle address-to-data alignment. An owner change never corrupts in-flight write data.

Simultaneous events:
- Owner drops request in the same cycle another master raises one: handover still costs one ARB_HANDOVER cycle.
- Requests arriving during Hreadyout=0 are sampled only at the next ready edge.

Other rules:
- Hreadyin = m_Hready = Hreadyout (combinational passthrough).
- Hgrant is always one-hot or zero; a multi-hot value is an assertion failure.

Optional Feature:
Macro: ARB_TIMEOUT_EN
- Defined:
  - The tenure counter increments on each ready edge in ARB_OWNED with Htrans out = 10.
  - When tenure reaches MAX_TENURE and another master requests, force ARB_HANDOVER even though the owner still requests.
  - The forced-out owner is skipped for that arbitration round.
  - tenure clears on every grant.
- Undefined:
  - No counter exists; the owner keeps the bus until it drops m_Hbusreq.

Decomposition:
- Shared package ahb_apb_pkg:
  - htrans_t enum: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - arb_state_t enum: ARB_IDLE, ARB_OWNED, ARB_HANDOVER.
  - Bridge address window constants 32'h8000_0000..32'h8BFF_FFFF.
- Sub-module rr_picker: combinational round-robin priority search (req, last, mask -> winner, any).

Test Plan:
1. Reset, then master 0 only requests a write at 32'h8000_0001 with Hwdata 32'hA3 -> Hgrant=4'b0001 after one ready edge; the bridge sees Haddr 32'h8000_0001 with NONSEQ; Hwdata=32'hA3 in the next cycle.
2. Masters 1 and 2 request together at reset -> master 1 is granted first. After master 1 drops its request: one cycle with Htrans=00 (ARB_HANDOVER), then Hgrant=4'b0100.
3. Handover while Hreadyout is held 0 for 3 cycles during master 1's write data phase -> Hwdata stays m_Hwdata[1] throughout; master 2's address is not forwarded until Hreadyout=1.
4. Round-robin wrap: all 4 masters request continuously and each drops after one transfer -> grant order 0,1,2,3,0.
5. ARB_TIMEOUT_EN with MAX_TENURE=2: master 0 streams reads to 32'h8400_0000 while master 3 requests -> after 2 NONSEQ transfers a forced handover occurs and Hgrant=4'b1000.
6. Hresetn driven low mid-write between clock edges -> Hgrant=0 and Htrans=00 immediately; arbitration restarts from master 0 after release.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// Shared types and constants for the AHB-to-APB bridge front end.
// Holds the AHB transfer encoding, the arbiter FSM states and the bridge
// address window.
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'b00,
        ARB_OWNED    = 2'b01,
        ARB_HANDOVER = 2'b10
    } arb_state_t;

    localparam logic [31:0] BRIDGE_ADDR_LO = 32'h8000_0000;
    localparam logic [31:0] BRIDGE_ADDR_HI = 32'h8BFF_FFFF;

    // True when an address falls inside the window decoded by the bridge.
    function automatic logic in_bridge_window(input logic [31:0] addr);
        return (addr >= BRIDGE_ADDR_LO) && (addr <= BRIDGE_ADDR_HI);
    endfunction

endpackage

// File: rtl/ahb_bridge_arbiter_chk.sv
// Property checker for the arbiter: the registered grant is one-hot or zero.
module ahb_bridge_arbiter_chk #(
    parameter int NUM_MASTERS = 4
) (
    input logic                   Hclk,
    input logic                   Hresetn,
    input logic [NUM_MASTERS-1:0] Hgrant
);

    a_grant_onehot0: assert property (@(posedge Hclk) disable iff (!Hresetn) $onehot0(Hgrant));

endmodule

// File: rtl/ahb_bridge_arbiter_rr_picker.sv
// Combinational round-robin search: first eligible requester after 'last',
// wrapping modulo N. Bits set in 'mask' are excluded from the search.
module rr_picker #(
    parameter int N  = 4,
    parameter int MW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [MW-1:0] last,
    input  logic [N-1:0]  mask,
    output logic [MW-1:0] winner,
    output logic          any
);

    logic [N-1:0] eligible_s;

    // Walk the N candidates starting one past the previous winner.
    always_comb begin
        logic [MW-1:0] idx_s;
        eligible_s = req & ~mask;
        winner     = '0;
        any        = 1'b0;
        idx_s      = '0;
        for (int i = 1; i <= N; i++) begin
            idx_s  = MW'((int'(last) + i) % N);
            winner = (!any && eligible_s[idx_s]) ? idx_s : winner;
            any    = any | eligible_s[idx_s];
        end
    end

endmodule

// File: rtl/ahb_bridge_arbiter.sv
// Round-robin arbiter sharing the bridge AHB slave port between masters.
// Address phase follows the granted owner (Hmaster); write data follows the
// data-phase owner (dmaster) one ready cycle later.
// Optional build macro ARB_TIMEOUT_EN limits each tenure to MAX_TENURE
// NONSEQ transfers when another master is waiting.
module ahb_bridge_arbiter
    import ahb_apb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_TENURE  = 16,
    parameter int MW          = $clog2(NUM_MASTERS)
) (
    input  logic                      Hclk,
    input  logic                      Hresetn,
    input  logic [NUM_MASTERS-1:0]    m_Hbusreq,
    input  logic [NUM_MASTERS*32-1:0] m_Haddr,
    input  logic [NUM_MASTERS*2-1:0]  m_Htrans,
    input  logic [NUM_MASTERS-1:0]    m_Hwrite,
    input  logic [NUM_MASTERS*32-1:0] m_Hwdata,
    input  logic                      Hreadyout,
    output logic [NUM_MASTERS-1:0]    Hgrant,
    output logic [MW-1:0]             Hmaster,
    output logic                      m_Hready,
    output logic [31:0]               Haddr,
    output logic [1:0]                Htrans,
    output logic                      Hwrite,
    output logic [31:0]               Hwdata,
    output logic                      Hreadyin
);

    arb_state_t             state_r, state_s;
    logic [NUM_MASTERS-1:0] grant_r, grant_s;
    logic [MW-1:0]          master_r, master_s;
    logic [MW-1:0]          dmaster_r;
    logic [MW-1:0]          last_r, last_s;
    logic [MW-1:0]          winner_s;
    logic                   any_s;
    logic [NUM_MASTERS-1:0] mask_s;
    logic                   force_s;
    logic                   skip_set_s;
    logic                   grant_evt_s;
    logic                   own_req_s;
    logic [1:0]             own_trans_s;

    assign own_req_s   = m_Hbusreq[master_r];
    assign own_trans_s = m_Htrans[int'(master_r) * 2 +: 2];

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(MAX_TENURE + 1);
    logic [TW-1:0]          tenure_r;
    logic [NUM_MASTERS-1:0] skip_r;
    logic                   tenure_inc_s;

    assign tenure_inc_s = (state_r == ARB_OWNED) && (Htrans == NONSEQ);
    // The edge completing the MAX_TENURE-th NONSEQ hands over if anyone waits.
    assign force_s = tenure_inc_s && (tenure_r >= TW'(MAX_TENURE - 1)) &&
                     (|(m_Hbusreq & ~grant_r));
    assign mask_s  = skip_r;

    // Tenure counter and forced-out owner mask, both advanced on ready edges.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            tenure_r <= '0;
            skip_r   <= '0;
        end else if (Hreadyout) begin
            skip_r <= skip_set_s ? grant_r : '0;
            if (grant_evt_s) begin
                tenure_r <= '0;
            end else if (tenure_inc_s && (tenure_r < TW'(MAX_TENURE))) begin
                tenure_r <= tenure_r + TW'(1);
            end
        end
    end
`else
    assign force_s = 1'b0;
    assign mask_s  = '0;
`endif

    rr_picker #(.N(NUM_MASTERS), .MW(MW)) u_picker (
        .req    (m_Hbusreq),
        .last   (last_r),
        .mask   (mask_s),
        .winner (winner_s),
        .any    (any_s)
    );

    // Next-state, next-grant and round-robin pointer selection.
    always_comb begin
        state_s     = state_r;
        grant_s     = grant_r;
        master_s    = master_r;
        last_s      = last_r;
        grant_evt_s = 1'b0;
        skip_set_s  = 1'b0;
        case (state_r)
            ARB_IDLE, ARB_HANDOVER: begin
                if (any_s) begin
                    state_s     = ARB_OWNED;
                    grant_s     = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << winner_s;
                    master_s    = winner_s;
                    last_s      = winner_s;
                    grant_evt_s = 1'b1;
                end else begin
                    state_s = ARB_IDLE;
                    grant_s = '0;
                end
            end
            ARB_OWNED: begin
                if (force_s) begin
                    state_s    = ARB_HANDOVER;
                    grant_s    = '0;
                    skip_set_s = 1'b1;
                end else if (!own_req_s && (own_trans_s == IDLE)) begin
                    state_s = ARB_HANDOVER;
                    grant_s = '0;
                end else begin
                    state_s = ARB_OWNED;
                end
            end
            default: begin
                state_s = ARB_IDLE;
                grant_s = '0;
            end
        endcase
    end

    // Arbiter registers; every update waits for a ready edge.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_r   <= ARB_IDLE;
            grant_r   <= '0;
            master_r  <= '0;
            dmaster_r <= '0;
            last_r    <= MW'(NUM_MASTERS - 1);
        end else if (Hreadyout) begin
            state_r  <= state_s;
            grant_r  <= grant_s;
            master_r <= master_s;
            last_r   <= last_s;
            if (Htrans[1]) begin
                dmaster_r <= master_r;
            end
        end
    end

    // Bridge-side mux; reset forces an idle bus without waiting for a clock.
    always_comb begin
        Htrans = IDLE;
        Haddr  = 32'h0000_0000;
        Hwrite = 1'b0;
        Hwdata = 32'h0000_0000;
        if (!Hresetn) begin
            Htrans = IDLE;
        end else begin
            Haddr  = m_Haddr[int'(master_r) * 32 +: 32];
            Hwrite = m_Hwrite[master_r];
            Hwdata = m_Hwdata[int'(dmaster_r) * 32 +: 32];
            case (state_r)
                ARB_OWNED: Htrans = own_trans_s;
                default:   Htrans = IDLE;
            endcase
        end
    end

    assign Hgrant   = grant_r;
    assign Hmaster  = master_r;
    assign m_Hready = Hreadyout;
    assign Hreadyin = Hreadyout;

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Directed bench for ahb_bridge_arbiter (4 masters, MAX_TENURE = 2).
module tb_ahb_bridge_arbiter;

    localparam int N = 4;

    logic            Hclk = 1'b0;
    logic            Hresetn;
    logic [N-1:0]    m_Hbusreq;
    logic [N*32-1:0] m_Haddr;
    logic [N*2-1:0]  m_Htrans;
    logic [N-1:0]    m_Hwrite;
    logic [N*32-1:0] m_Hwdata;
    logic            Hreadyout;
    logic [N-1:0]    Hgrant;
    logic [1:0]      Hmaster;
    logic            m_Hready;
    logic [31:0]     Haddr;
    logic [1:0]      Htrans;
    logic            Hwrite;
    logic [31:0]     Hwdata;
    logic            Hreadyin;

    int checks_cnt = 0;
    int errors_cnt = 0;

    ahb_bridge_arbiter #(.NUM_MASTERS(N), .MAX_TENURE(2)) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .m_Hbusreq(m_Hbusreq), .m_Haddr(m_Haddr),
        .m_Htrans(m_Htrans), .m_Hwrite(m_Hwrite), .m_Hwdata(m_Hwdata),
        .Hreadyout(Hreadyout), .Hgrant(Hgrant), .Hmaster(Hmaster), .m_Hready(m_Hready),
        .Haddr(Haddr), .Htrans(Htrans), .Hwrite(Hwrite), .Hwdata(Hwdata), .Hreadyin(Hreadyin)
    );

    ahb_bridge_arbiter_chk #(.NUM_MASTERS(N)) u_chk (
        .Hclk(Hclk), .Hresetn(Hresetn), .Hgrant(Hgrant)
    );

    always #5 Hclk = ~Hclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic set_m(input int i, input logic req, input logic [1:0] tr,
                         input logic wr, input logic [31:0] a, input logic [31:0] d);
        m_Hbusreq[i]        = req;
        m_Htrans[i*2 +: 2]  = tr;
        m_Hwrite[i]         = wr;
        m_Haddr[i*32 +: 32] = a;
        m_Hwdata[i*32 +: 32] = d;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) set_m(i, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic pulse_reset();
        Hresetn = 1'b0;
        #2;
        Hresetn = 1'b1;
    endtask

    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        Hresetn   = 1'b0;
        Hreadyout = 1'b1;
        clear_all();

        // 1: reset state with master 0 already presenting a write
        set_m(0, 1'b1, 2'b10, 1'b1, 32'h8000_0001, 32'h0000_00A3);
        #1;
        check("rst_grant",  Hgrant,  32'h0);
        check("rst_master", Hmaster, 32'h0);
        check("rst_trans",  Htrans,  32'h0);
        check("rst_addr",   Haddr,   32'h0);
        check("rst_wdata",  Hwdata,  32'h0);
        check("rst_hwrite", Hwrite,  32'h0);
        check("rst_ready",  {m_Hready, Hreadyin}, 32'h3);
        tick();
        tick();
        check("rst_grant_hold", Hgrant, 32'h0);
        Hresetn = 1'b1;
        tick();
        check("t1_grant",  Hgrant, 32'h1);
        check("t1_master", Hmaster, 32'h0);
        check("t1_trans",  Htrans, 32'h2);
        check("t1_addr",   Haddr,  32'h8000_0001);
        check("t1_write",  Hwrite, 32'h1);
        tick();
        set_m(0, 1'b0, 2'b00, 1'b1, 32'h8000_0001, 32'h0000_00A3);
        check("t1_wdata", Hwdata, 32'hA3);
        tick();
        check("t1_ho_trans", Htrans, 32'h0);
        check("t1_ho_grant", Hgrant, 32'h0);
        check("t1_ho_addr",  Haddr,  32'h8000_0001);
        tick();
        check("t1_idle_grant", Hgrant, 32'h0);

        // 2/3: masters 1 and 2 together after reset; stall during m1 data phase
        clear_all();
        pulse_reset();
        set_m(1, 1'b1, 2'b10, 1'b1, 32'h8000_0010, 32'h1111_0001);
        set_m(2, 1'b1, 2'b10, 1'b1, 32'h8000_0020, 32'h2222_0002);
        tick();
        check("t2_grant1", Hgrant,  32'h2);
        check("t2_master1", Hmaster, 32'h1);
        check("t2_addr1",  Haddr,   32'h8000_0010);
        tick();
        set_m(1, 1'b0, 2'b00, 1'b1, 32'h8000_0010, 32'h1111_0001);
        m_Hwdata[2*32 +: 32] = 32'h2222_00FF;
        Hreadyout = 1'b0;
        #1;
        check("t3_hready_bcast", {m_Hready, Hreadyin}, 32'h0);
        for (int c = 0; c < 3; c++) begin
            check("t3_wdata_stall", Hwdata, 32'h1111_0001);
            check("t3_grant_stall", Hgrant, 32'h2);
            check("t3_addr_stall",  Haddr,  32'h8000_0010);
            check("t3_trans_stall", Htrans, 32'h0);
            tick();
        end
        Hreadyout = 1'b1;
        check("t3_wdata_release", Hwdata, 32'h1111_0001);
        tick();
        check("t2_ho_trans", Htrans, 32'h0);
        check("t2_ho_grant", Hgrant, 32'h0);
        check("t2_ho_addr",  Haddr,  32'h8000_0010);
        tick();
        check("t2_grant2",  Hgrant,  32'h4);
        check("t2_master2", Hmaster, 32'h2);
        check("t2_trans2",  Htrans,  32'h2);
        check("t2_addr2",   Haddr,   32'h8000_0020);
        tick();
        set_m(2, 1'b0, 2'b00, 1'b1, 32'h8000_0020, 32'h2222_00FF);
        check("t2_wdata2", Hwdata, 32'h2222_00FF);
        tick();
        tick();
        check("t2_idle", Hgrant, 32'h0);

        // 4: round-robin wrap with all four masters requesting
        clear_all();
        pulse_reset();
        for (int i = 0; i < N; i++) set_m(i, 1'b1, 2'b10, 1'b0, 32'h8000_0100 + 32'(i), 32'h0);
        for (int k = 0; k < 5; k++) begin
            int w;
            w = order[k];
            tick();
            check("t4_grant",  Hgrant,  32'(1) << w);
            check("t4_master", Hmaster, 32'(w));
            check("t4_addr",   Haddr,   32'h8000_0100 + 32'(w));
            tick();
            m_Hbusreq[w]       = 1'b0;
            m_Htrans[w*2 +: 2] = 2'b00;
            tick();
            check("t4_ho_trans", Htrans, 32'h0);
            m_Hbusreq[w]       = 1'b1;
            m_Htrans[w*2 +: 2] = 2'b10;
        end

        // 5: tenure limit, master 0 streaming reads while master 3 waits
        clear_all();
        pulse_reset();
        set_m(0, 1'b1, 2'b10, 1'b0, 32'h8400_0000, 32'h0);
        set_m(3, 1'b1, 2'b00, 1'b0, 32'h8000_0300, 32'h0);
        tick();
        check("t5_grant0", Hgrant, 32'h1);
        check("t5_trans",  Htrans, 32'h2);
        check("t5_addr",   Haddr,  32'h8400_0000);
        check("t5_write",  Hwrite, 32'h0);
        tick();
        check("t5_grant0_after1", Hgrant, 32'h1);
        tick();
`ifdef ARB_TIMEOUT_EN
        check("t5_forced_ho_grant", Hgrant, 32'h0);
        check("t5_forced_ho_trans", Htrans, 32'h0);
        tick();
        check("t5_grant3", Hgrant, 32'h8);
        check("t5_master3", Hmaster, 32'h3);
`else
        check("t5_keep_grant", Hgrant, 32'h1);
        tick();
        check("t5_keep_grant2", Hgrant, 32'h1);
`endif
        clear_all();
        tick();
        tick();
        check("t5_idle", Hgrant, 32'h0);

        // 6: reset between edges during a write, then restart from master 0
        set_m(1, 1'b1, 2'b10, 1'b1, 32'h8000_0500, 32'h5555_0001);
        tick();
        check("t6_grant1", Hgrant, 32'h2);
        #2;
        Hresetn = 1'b0;
        #1;
        check("t6_rst_grant", Hgrant, 32'h0);
        check("t6_rst_trans", Htrans, 32'h0);
        check("t6_rst_wdata", Hwdata, 32'h0);
        #2;
        Hresetn = 1'b1;
        set_m(2, 1'b1, 2'b10, 1'b1, 32'h8000_0600, 32'h6666_0001);
        tick();
        check("t6_restart_grant",  Hgrant,  32'h2);
        check("t6_restart_master", Hmaster, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
